// File: rtl/ne555_step_sequencer.sv
// -----------------------------------------------------------------------------
// ne555_step_sequencer
//
// Purpose
//   Programmable step sequencer that owns the control pins of one NE555EX
//   timer core. A small table holds NSTEPS steps. Each step sets the timer mode,
//   rate and duty, and how long the step lasts. Once started, the steps play in
//   order, either once or looped. Every step entry issues a phase-reset (sync)
//   pulse. An entry into a mono-mode step also issues a trigger (fire) pulse.
//
// Parameters
//   NSTEPS      table depth, power of two, 2..16
//   TICK_SHIFT  one duration unit = 2^TICK_SHIFT clk cycles (0..15)
//
// Ports
//   clk         single clock
//   rst         synchronous, active-high reset (the table is not cleared)
//   wr_en       table write strobe
//   wr_addr     table entry to write
//   wr_data     {last[18], mode[17:16], rate[15:12], duty[11:8], dur[7:0]}
//   start       1-cycle start request (honoured in IDLE only)
//   stop        1-cycle abort request (honoured in RUN only, wins all ties)
//   loop_en     wrap to step 0 after a last step; sampled at each step end
//   tmr_enable  timer enable
//   tmr_mode    timer mode (00 mono, 01 astable, 10 pwm, 11 burst)
//   tmr_rate    timer prescaler rate
//   tmr_duty    timer PWM duty
//   tmr_sync    1-cycle phase-reset pulse on every step entry
//   tmr_fire    1-cycle trigger on entry into a mode-00 step
//   busy        high while running
//   step_idx    current step index
//   seq_done    1-cycle pulse when a sequence ends or is stopped
// -----------------------------------------------------------------------------
module ne555_step_sequencer #(
    parameter int NSTEPS     = 8,
    parameter int TICK_SHIFT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [$clog2(NSTEPS)-1:0] wr_addr,
    input  logic [18:0]               wr_data,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      loop_en,
    output logic                      tmr_enable,
    output logic [1:0]                tmr_mode,
    output logic [3:0]                tmr_rate,
    output logic [3:0]                tmr_duty,
    output logic                      tmr_sync,
    output logic                      tmr_fire,
    output logic                      busy,
    output logic [$clog2(NSTEPS)-1:0] step_idx,
    output logic                      seq_done
);

    localparam int IW = $clog2(NSTEPS);
    // A zero-width prescaler is not legal, so keep at least one bit and
    // ignore it when TICK_SHIFT is 0.
    localparam int PW = (TICK_SHIFT > 0) ? TICK_SHIFT : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NSTEPS - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Step table: deliberately not reset, contents survive rst.
    logic [18:0]   r_table [NSTEPS];

    state_t        r_state;
    logic          r_enable;
    logic [1:0]    r_mode;
    logic [3:0]    r_rate;
    logic [3:0]    r_duty;
    logic          r_sync;
    logic          r_fire;
    logic          r_busy;
    logic [IW-1:0] r_step_idx;
    logic          r_done;

    logic [PW-1:0] r_presc;
    logic [7:0]    r_units;
    logic          r_cur_last;   // last flag of the step being played

    logic          w_presc_full;
    logic          w_tick;
    logic          w_step_end;
    logic          w_last;
    logic          w_enter;
    logic          w_finish;
    logic [IW-1:0] w_next_idx;
    logic [18:0]   w_entry;
    logic          w_e_last;
    logic [1:0]    w_e_mode;
    logic [3:0]    w_e_rate;
    logic [3:0]    w_e_duty;
    logic [7:0]    w_e_dur;
    logic [7:0]    w_e_units;

    // -------------------------------------------------------------------------
    // Table write port
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_table[wr_addr] <= wr_data;
        end
    end

    // -------------------------------------------------------------------------
    // Duration timing
    // -------------------------------------------------------------------------
    generate
        if (TICK_SHIFT == 0) begin : g_no_presc
            assign w_presc_full = 1'b1;
        end else begin : g_presc
            assign w_presc_full = (r_presc == {PW{1'b1}});
        end
    endgenerate

    assign w_tick     = (r_state == S_RUN) && w_presc_full;
    // The step ends on the final cycle of its last unit.
    assign w_step_end = w_tick && (r_units == 8'd1);
    // The top table slot always acts as a last step.
    assign w_last     = r_cur_last || (r_step_idx == LAST_IDX);

    // -------------------------------------------------------------------------
    // Next-action decode
    // -------------------------------------------------------------------------
    always_comb begin
        w_enter    = 1'b0;
        w_finish   = 1'b0;
        w_next_idx = '0;
        case (r_state)
            S_IDLE: begin
                // stop wins over start, even in IDLE
                if (start && !stop) begin
                    w_enter = 1'b1;
                end
            end
            S_RUN: begin
                // stop also wins over a step end, so no entry happens
                if (stop) begin
                    w_finish = 1'b1;
                end else if (w_step_end) begin
                    if (!w_last) begin
                        w_enter    = 1'b1;
                        w_next_idx = r_step_idx + 1'b1;
                    end else if (loop_en) begin
                        w_enter    = 1'b1;
                    end else begin
                        w_finish   = 1'b1;
                    end
                end
            end
            default: begin
                w_finish = 1'b1;
            end
        endcase
    end

    // The fields of the step about to be entered are fetched here. Any table
    // write in the same cycle lands afterwards.
    assign w_entry   = r_table[w_next_idx];
    assign w_e_last  = w_entry[18];
    assign w_e_mode  = w_entry[17:16];
    assign w_e_rate  = w_entry[15:12];
    assign w_e_duty  = w_entry[11:8];
    assign w_e_dur   = w_entry[7:0];
    assign w_e_units = (w_e_dur == 8'd0) ? 8'd1 : w_e_dur;

    // -------------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_enable   <= 1'b0;
            r_mode     <= 2'b00;
            r_rate     <= 4'd0;
            r_duty     <= 4'd0;
            r_sync     <= 1'b0;
            r_fire     <= 1'b0;
            r_busy     <= 1'b0;
            r_step_idx <= '0;
            r_done     <= 1'b0;
            r_presc    <= '0;
            r_units    <= 8'd0;
            r_cur_last <= 1'b0;
        end else begin
            // Pulse outputs default low; only an entry or a finish raises them.
            r_sync <= 1'b0;
            r_fire <= 1'b0;
            r_done <= 1'b0;
            if (w_enter) begin
                r_state    <= S_RUN;
                r_enable   <= 1'b1;
                r_busy     <= 1'b1;
                r_mode     <= w_e_mode;
                r_rate     <= w_e_rate;
                r_duty     <= w_e_duty;
                r_sync     <= 1'b1;
                r_fire     <= (w_e_mode == 2'b00);
                r_step_idx <= w_next_idx;
                r_presc    <= '0;
                r_units    <= w_e_units;
                r_cur_last <= w_e_last;
            end else if (w_finish) begin
                // step_idx holds so the host can see where the sequence ended
                r_state    <= S_IDLE;
                r_enable   <= 1'b0;
                r_busy     <= 1'b0;
                r_mode     <= 2'b00;
                r_rate     <= 4'd0;
                r_duty     <= 4'd0;
                r_done     <= 1'b1;
                r_presc    <= '0;
                r_units    <= 8'd0;
                r_cur_last <= 1'b0;
            end else if (r_state == S_RUN) begin
                r_presc <= r_presc + 1'b1;
                if (w_tick) begin
                    r_units <= r_units - 8'd1;
                end
            end
        end
    end

    assign tmr_enable = r_enable;
    assign tmr_mode   = r_mode;
    assign tmr_rate   = r_rate;
    assign tmr_duty   = r_duty;
    assign tmr_sync   = r_sync;
    assign tmr_fire   = r_fire;
    assign busy       = r_busy;
    assign step_idx   = r_step_idx;
    assign seq_done   = r_done;

endmodule
